// File: rtl/fixed_gqa_head_scatter_if.sv
// Handshake bundle between the joint QKV streams, the per-head split streams
// and the head-index outputs of fixed_gqa_head_scatter.
interface fixed_gqa_head_scatter_if #(
    parameter int unsigned NUM_HEADS    = 12,
    parameter int unsigned NUM_KV_HEADS = 4
);
    localparam int unsigned HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
    localparam int unsigned GW = (NUM_KV_HEADS > 1) ? $clog2(NUM_KV_HEADS) : 1;

    logic                 query_valid;
    logic                 query_ready;
    logic                 key_valid;
    logic                 key_ready;
    logic                 value_valid;
    logic                 value_ready;
    logic [NUM_HEADS-1:0] split_query_valid;
    logic [NUM_HEADS-1:0] split_query_ready;
    logic [NUM_HEADS-1:0] split_key_valid;
    logic [NUM_HEADS-1:0] split_key_ready;
    logic [NUM_HEADS-1:0] split_value_valid;
    logic [NUM_HEADS-1:0] split_value_ready;
    logic [HW-1:0]        query_head_idx;
    logic [GW-1:0]        kv_group_idx;

    // Scatter side: consumes the joint streams, drives the per-head streams.
    modport slave (
        input  query_valid, key_valid, value_valid,
        input  split_query_ready, split_key_ready, split_value_ready,
        output query_ready, key_ready, value_ready,
        output split_query_valid, split_key_valid, split_value_valid,
        output query_head_idx, kv_group_idx
    );

    // Environment side: produces the joint streams, plays the heads.
    modport master (
        output query_valid, key_valid, value_valid,
        output split_query_ready, split_key_ready, split_value_ready,
        input  query_ready, key_ready, value_ready,
        input  split_query_valid, split_key_valid, split_value_valid,
        input  query_head_idx, kv_group_idx
    );
endinterface

// File: rtl/fixed_gqa_head_scatter.sv
// GQA control-path scatter: one-hot query routing, group broadcast of key/value.
// Optional stall counters enabled with GQA_SCATTER_PERF_EN.
module fixed_gqa_head_scatter #(
    parameter int unsigned NUM_HEADS                 = 12,
    parameter int unsigned NUM_KV_HEADS              = 4,
    parameter int unsigned HEAD_DIM                  = 64,
    parameter int unsigned IN_DATA_TENSOR_SIZE_DIM_1 = 20,
    parameter int unsigned IN_DATA_PARALLELISM_DIM_0 = 4,
    parameter int unsigned IN_DATA_PARALLELISM_DIM_1 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fixed_gqa_head_scatter_if.slave    bus
`ifdef GQA_SCATTER_PERF_EN
    ,
    output logic [31:0]                kv_stall_cycles,
    output logic [31:0]                q_stall_cycles
`endif
);
    localparam int unsigned GROUP   = NUM_HEADS / NUM_KV_HEADS;
    localparam int unsigned BPH     = HEAD_DIM / IN_DATA_PARALLELISM_DIM_0;
    localparam int unsigned ROWS    = (IN_DATA_TENSOR_SIZE_DIM_1 + IN_DATA_PARALLELISM_DIM_1 - 1)
                                      / IN_DATA_PARALLELISM_DIM_1;
    localparam int unsigned Q_COLS  = NUM_HEADS * BPH;
    localparam int unsigned KV_COLS = NUM_KV_HEADS * BPH;
    localparam int unsigned QCW     = (Q_COLS > 1) ? $clog2(Q_COLS) : 1;
    localparam int unsigned KCW     = (KV_COLS > 1) ? $clog2(KV_COLS) : 1;
    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned HW      = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
    localparam int unsigned GW      = (NUM_KV_HEADS > 1) ? $clog2(NUM_KV_HEADS) : 1;

    // ---------------- query: one-hot, zero latency ----------------
    logic [QCW-1:0] q_col;
    logic [RW-1:0]  q_row;
    logic [HW-1:0]  q_head;
    logic           q_fire;

    assign q_head                = HW'(32'(q_col) / BPH);
    assign bus.query_head_idx    = q_head;
    assign bus.split_query_valid = NUM_HEADS'(bus.query_valid) << q_head;
    assign bus.query_ready       = bus.split_query_ready[q_head];
    assign q_fire                = bus.query_valid & bus.query_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_col <= '0;
            q_row <= '0;
        end else if (q_fire) begin
            if (q_col == QCW'(Q_COLS - 1)) begin
                q_col <= '0;
                q_row <= (q_row == RW'(ROWS - 1)) ? '0 : q_row + RW'(1);
            end else begin
                q_col <= q_col + QCW'(1);
            end
        end
    end

    // ---------------- key (lane 0) and value (lane 1) broadcast ----------------
    logic [1:0]                kv_valid;
    logic [1:0]                kv_ready;
    logic [1:0][NUM_HEADS-1:0] kv_split_ready;
    logic [1:0][NUM_HEADS-1:0] kv_split_valid;
`ifdef GQA_SCATTER_PERF_EN
    logic [1:0]                kv_skew;
`endif

    assign kv_valid              = {bus.value_valid, bus.key_valid};
    assign kv_split_ready        = {bus.split_value_ready, bus.split_key_ready};
    assign bus.split_key_valid   = kv_split_valid[0];
    assign bus.split_value_valid = kv_split_valid[1];
    assign bus.key_ready         = kv_ready[0];
    assign bus.value_ready       = kv_ready[1];

    for (genvar s = 0; s < 2; s++) begin : g_kv
        logic [KCW-1:0]   col;
        logic [RW-1:0]    row;
        logic [GW-1:0]    grp;
        logic [GROUP-1:0] done;
        logic [GROUP-1:0] grp_ready;
        logic             lane_ready;
        logic             fire;

        assign grp        = GW'(32'(col) / BPH);
        assign grp_ready  = GROUP'(kv_split_ready[s] >> (32'(grp) * GROUP));
        // Members that already took this beat count as ready; they are not re-offered.
        assign lane_ready = &(done | grp_ready);
        assign fire       = kv_valid[s] & lane_ready;
        assign kv_ready[s] = lane_ready;
        assign kv_split_valid[s] =
            NUM_HEADS'({GROUP{kv_valid[s]}} & ~done) << (32'(grp) * GROUP);
`ifdef GQA_SCATTER_PERF_EN
        assign kv_skew[s] = kv_valid[s] & (|done);
`endif

        if (s == 0) begin : g_idx
            assign bus.kv_group_idx = grp;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                col  <= '0;
                row  <= '0;
                done <= '0;
            end else if (fire) begin
                done <= '0;
                if (col == KCW'(KV_COLS - 1)) begin
                    col <= '0;
                    row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + KCW'(1);
                end
            end else if (kv_valid[s]) begin
                done <= done | grp_ready;
            end
        end
    end

`ifdef GQA_SCATTER_PERF_EN
    // Saturating stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            kv_stall_cycles <= '0;
            q_stall_cycles  <= '0;
        end else begin
            if ((|kv_skew) && (kv_stall_cycles != '1))
                kv_stall_cycles <= kv_stall_cycles + 32'd1;
            if (bus.query_valid && !bus.query_ready && (q_stall_cycles != '1))
                q_stall_cycles <= q_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fixed_gqa_head_scatter.sv
// Randomized and directed bench for fixed_gqa_head_scatter against a beat-index
// reference model (GROUP=2, BPH=2, Q_COLS=8, KV_COLS=4, ROWS=2).
module tb_fixed_gqa_head_scatter;
    localparam int NH = 4, NKV = 2, HD = 8, D1 = 4, P0 = 4, P1 = 2;
    localparam int GROUP = NH / NKV, BPH = HD / P0, ROWS = (D1 + P1 - 1) / P1;
    localparam int QC = NH * BPH, KC = NKV * BPH;
    localparam int Q_BEATS = QC * ROWS, KV_BEATS = KC * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixed_gqa_head_scatter_if #(.NUM_HEADS(NH), .NUM_KV_HEADS(NKV)) bus ();
`ifdef GQA_SCATTER_PERF_EN
    logic [31:0] kv_stall_cycles, q_stall_cycles;
`endif

    fixed_gqa_head_scatter #(
        .NUM_HEADS(NH), .NUM_KV_HEADS(NKV), .HEAD_DIM(HD),
        .IN_DATA_TENSOR_SIZE_DIM_1(D1), .IN_DATA_PARALLELISM_DIM_0(P0),
        .IN_DATA_PARALLELISM_DIM_1(P1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef GQA_SCATTER_PERF_EN
        ,
        .kv_stall_cycles(kv_stall_cycles),
        .q_stall_cycles(q_stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: beat index within tensor per stream (0=q, 1=k, 2=v) and
    // the set of heads that already accepted the current k/v beat.
    int         m_beat [3];
    logic [3:0] m_acc  [3];
    logic       m_pend [3] = '{1'b0, 1'b0, 1'b0};
    int         e_kv_stall = 0;
    int         e_q_stall  = 0;

    function automatic logic [3:0] kv_mask(input int beat);
        int g;
        logic [3:0] m;
        g = (beat % KC) / BPH;
        m = '0;
        for (int h = 0; h < NH; h++) if (h / GROUP == g) m[h] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] exp_kv_valid(input logic v, input int beat, input logic [3:0] acc);
        return v ? (kv_mask(beat) & ~acc) : 4'b0000;
    endfunction

    function automatic logic exp_kv_ready(input int beat, input logic [3:0] acc, input logic [3:0] rdy);
        return (kv_mask(beat) & ~(acc | rdy)) == 4'b0000;
    endfunction

    function automatic logic [3:0] exp_q_valid(input logic v, input int beat);
        logic [3:0] one;
        one = 4'b0001;
        return v ? (one << ((beat % QC) / BPH)) : 4'b0000;
    endfunction

    function automatic logic exp_q_ready(input int beat, input logic [3:0] rdy);
        return rdy[(beat % QC) / BPH];
    endfunction

    // Advance the reference model over one clock edge, then settle past it.
    task automatic tick();
        logic qr, v, rd;
        logic [3:0] r;
        qr = exp_q_ready(m_beat[0], bus.split_query_ready);
        if (!rst) begin
            assert (!(m_pend[1] && !bus.key_valid)) else $error("key_valid dropped mid-broadcast");
            assert (!(m_pend[2] && !bus.value_valid)) else $error("value_valid dropped mid-broadcast");
        end
        if (rst) begin
            e_kv_stall = 0;
            e_q_stall  = 0;
        end else begin
            if ((bus.key_valid && m_acc[1] != 0) || (bus.value_valid && m_acc[2] != 0)) e_kv_stall++;
            if (bus.query_valid && !qr) e_q_stall++;
        end
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                m_beat[s] = 0;
                m_acc[s]  = '0;
                m_pend[s] = 1'b0;
            end
        end else begin
            if (bus.query_valid && qr) m_beat[0] = (m_beat[0] + 1) % Q_BEATS;
            for (int s = 1; s < 3; s++) begin
                v  = (s == 1) ? bus.key_valid : bus.value_valid;
                r  = (s == 1) ? bus.split_key_ready : bus.split_value_ready;
                rd = exp_kv_ready(m_beat[s], m_acc[s], r);
                m_pend[s] = v && !rd;
                if (v && rd) begin
                    m_beat[s] = (m_beat[s] + 1) % KV_BEATS;
                    m_acc[s]  = '0;
                end else if (v) begin
                    m_acc[s] = m_acc[s] | (r & kv_mask(m_beat[s]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic qv, input logic kv, input logic vv,
                         input logic [3:0] qr, input logic [3:0] kr, input logic [3:0] vr);
        bus.query_valid = qv;
        bus.key_valid   = kv;
        bus.value_valid = vv;
        bus.split_query_ready = qr;
        bus.split_key_ready   = kr;
        bus.split_value_ready = vr;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] qr, kr, vr;
        rst = 1'b1;
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        qr = 4'($urandom); kr = 4'($urandom); vr = 4'($urandom);
        drive(0, 0, 0, qr, kr, vr);
        n_checks++; if (bus.split_query_valid !== 4'b0) $display("FAIL reset_sqv got %b want 0000", bus.split_query_valid); else n_pass++;
        n_checks++; if (bus.split_key_valid !== 4'b0) $display("FAIL reset_skv got %b want 0000", bus.split_key_valid); else n_pass++;
        n_checks++; if (bus.split_value_valid !== 4'b0) $display("FAIL reset_svv got %b want 0000", bus.split_value_valid); else n_pass++;
        n_checks++; if (bus.query_head_idx !== 2'd0) $display("FAIL reset_qidx got %0d want 0", bus.query_head_idx); else n_pass++;
        n_checks++; if (bus.kv_group_idx !== 1'b0) $display("FAIL reset_kvidx got %0d want 0", bus.kv_group_idx); else n_pass++;
        n_checks++; if (bus.query_ready !== qr[0]) $display("FAIL reset_qready got %b want %b", bus.query_ready, qr[0]); else n_pass++;
        n_checks++; if (bus.key_ready !== (kr[0] & kr[1])) $display("FAIL reset_kready got %b want %b", bus.key_ready, kr[0] & kr[1]); else n_pass++;
        n_checks++; if (bus.value_ready !== (vr[0] & vr[1])) $display("FAIL reset_vready got %b want %b", bus.value_ready, vr[0] & vr[1]); else n_pass++;
        rst = 1'b0;
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_query_sweep();
        int seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        logic [3:0] one;
        one = 4'b0001;
        apply_reset();
        drive(1, 0, 0, 4'hF, 4'h0, 4'h0);
        for (int b = 0; b < 17; b++) begin
            n_checks++; if (bus.query_head_idx !== 2'(seq[b % 8])) $display("FAIL qsweep_idx beat %0d got %0d want %0d", b, bus.query_head_idx, seq[b % 8]); else n_pass++;
            n_checks++; if (bus.split_query_valid !== (one << seq[b % 8])) $display("FAIL qsweep_valid beat %0d got %b want %b", b, bus.split_query_valid, one << seq[b % 8]); else n_pass++;
            n_checks++; if (bus.query_ready !== 1'b1) $display("FAIL qsweep_ready beat %0d got %b want 1", b, bus.query_ready); else n_pass++;
            tick();
        end
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_key_broadcast();
        logic [3:0] exp_v [4] = '{4'b0011, 4'b0011, 4'b1100, 4'b1100};
        apply_reset();
        drive(0, 1, 0, 4'h0, 4'hF, 4'h0);
        for (int b = 0; b < 4; b++) begin
            n_checks++; if (bus.split_key_valid !== exp_v[b]) $display("FAIL kbcast_valid beat %0d got %b want %b", b, bus.split_key_valid, exp_v[b]); else n_pass++;
            n_checks++; if (bus.key_ready !== 1'b1) $display("FAIL kbcast_ready beat %0d got %b want 1", b, bus.key_ready); else n_pass++;
            n_checks++; if (bus.kv_group_idx !== 1'(b / 2)) $display("FAIL kbcast_grp beat %0d got %0d want %0d", b, bus.kv_group_idx, b / 2); else n_pass++;
            tick();
        end
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_skew();
        logic [3:0] rdy;
        logic [3:0] ev;
        logic       er;
        int cnt [4] = '{0, 0, 0, 0};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            rdy = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
            drive(0, 1, 0, 4'h0, rdy, 4'h0);
            ev = (c == 0) ? 4'b0011 : 4'b0010;
            er = (c == 3);
            n_checks++; if (bus.split_key_valid !== ev) $display("FAIL skew_valid cycle %0d got %b want %b", c, bus.split_key_valid, ev); else n_pass++;
            n_checks++; if (bus.key_ready !== er) $display("FAIL skew_ready cycle %0d got %b want %b", c, bus.key_ready, er); else n_pass++;
            for (int h = 0; h < 4; h++) if (bus.split_key_valid[h] && bus.split_key_ready[h]) cnt[h]++;
            tick();
        end
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
        n_checks++; if (cnt[0] != 1 || cnt[1] != 1 || cnt[2] != 0 || cnt[3] != 0)
            $display("FAIL skew_accepts got %0d/%0d/%0d/%0d want 1/1/0/0", cnt[0], cnt[1], cnt[2], cnt[3]); else n_pass++;
`ifdef GQA_SCATTER_PERF_EN
        n_checks++; if (kv_stall_cycles !== 32'd3) $display("FAIL perf_kv_stall got %0d want 3", kv_stall_cycles); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (kv_stall_cycles !== 32'd0) $display("FAIL perf_kv_clear got %0d want 0", kv_stall_cycles); else n_pass++;
`endif
    endtask

    task automatic test_independent();
        apply_reset();
        for (int b = 0; b < 6; b++) begin
            drive(0, 1, 1, 4'h0, 4'hF, 4'h0);
            if (b < 4) begin
                n_checks++; if (bus.kv_group_idx !== 1'(b / 2)) $display("FAIL indep_kgrp beat %0d got %0d want %0d", b, bus.kv_group_idx, b / 2); else n_pass++;
            end
            n_checks++; if (bus.split_value_valid !== 4'b0011) $display("FAIL indep_vvalid beat %0d got %b want 0011", b, bus.split_value_valid); else n_pass++;
            n_checks++; if (bus.value_ready !== 1'b0) $display("FAIL indep_vready beat %0d got %b want 0", b, bus.value_ready); else n_pass++;
            tick();
        end
        // Key now at beat 6 (group 1); value still at beat 0 (group 0).
        drive(0, 1, 1, 4'h0, 4'h0, 4'h0);
        n_checks++; if (bus.split_key_valid !== 4'b1100) $display("FAIL indep_kvalid got %b want 1100", bus.split_key_valid); else n_pass++;
        n_checks++; if (bus.split_value_valid !== 4'b0011) $display("FAIL indep_vstill got %b want 0011", bus.split_value_valid); else n_pass++;
        drive(0, 1, 1, 4'h0, 4'hF, 4'hF);
        tick();
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(0, 1, 0, 4'h0, 4'b0001, 4'h0);
        tick();
        drive(0, 1, 0, 4'h0, 4'b0000, 4'h0);
        tick();
        rst = 1'b1;
        drive(0, 1, 0, 4'h0, 4'b0000, 4'h0);
        tick();
        rst = 1'b0;
        drive(0, 1, 0, 4'h0, 4'b0000, 4'h0);
        n_checks++; if (bus.split_key_valid !== 4'b0011) $display("FAIL rstmid_valid got %b want 0011", bus.split_key_valid); else n_pass++;
        n_checks++; if (bus.kv_group_idx !== 1'b0) $display("FAIL rstmid_grp got %0d want 0", bus.kv_group_idx); else n_pass++;
        n_checks++; if (bus.key_ready !== 1'b0) $display("FAIL rstmid_ready got %b want 0", bus.key_ready); else n_pass++;
        drive(0, 1, 0, 4'h0, 4'b0011, 4'h0);
        n_checks++; if (bus.key_ready !== 1'b1) $display("FAIL rstmid_retire got %b want 1", bus.key_ready); else n_pass++;
        tick();
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_random();
        logic qv, kv, vv;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            qv = m_pend[0] ? 1'b1 : ($urandom_range(0, 3) != 0);
            kv = m_pend[1] ? 1'b1 : ($urandom_range(0, 3) != 0);
            vv = m_pend[2] ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(qv, kv, vv, 4'($urandom), 4'($urandom), 4'($urandom));
            n_checks++; if (bus.split_query_valid !== exp_q_valid(qv, m_beat[0])) $display("FAIL rnd_qvalid c%0d got %b want %b", c, bus.split_query_valid, exp_q_valid(qv, m_beat[0])); else n_pass++;
            n_checks++; if (bus.query_ready !== exp_q_ready(m_beat[0], bus.split_query_ready)) $display("FAIL rnd_qready c%0d got %b want %b", c, bus.query_ready, exp_q_ready(m_beat[0], bus.split_query_ready)); else n_pass++;
            n_checks++; if (bus.query_head_idx !== 2'((m_beat[0] % QC) / BPH)) $display("FAIL rnd_qidx c%0d got %0d want %0d", c, bus.query_head_idx, (m_beat[0] % QC) / BPH); else n_pass++;
            n_checks++; if (bus.split_key_valid !== exp_kv_valid(kv, m_beat[1], m_acc[1])) $display("FAIL rnd_kvalid c%0d got %b want %b", c, bus.split_key_valid, exp_kv_valid(kv, m_beat[1], m_acc[1])); else n_pass++;
            n_checks++; if (bus.key_ready !== exp_kv_ready(m_beat[1], m_acc[1], bus.split_key_ready)) $display("FAIL rnd_kready c%0d got %b want %b", c, bus.key_ready, exp_kv_ready(m_beat[1], m_acc[1], bus.split_key_ready)); else n_pass++;
            n_checks++; if (bus.kv_group_idx !== 1'((m_beat[1] % KC) / BPH)) $display("FAIL rnd_kgrp c%0d got %0d want %0d", c, bus.kv_group_idx, (m_beat[1] % KC) / BPH); else n_pass++;
            n_checks++; if (bus.split_value_valid !== exp_kv_valid(vv, m_beat[2], m_acc[2])) $display("FAIL rnd_vvalid c%0d got %b want %b", c, bus.split_value_valid, exp_kv_valid(vv, m_beat[2], m_acc[2])); else n_pass++;
            n_checks++; if (bus.value_ready !== exp_kv_ready(m_beat[2], m_acc[2], bus.split_value_ready)) $display("FAIL rnd_vready c%0d got %b want %b", c, bus.value_ready, exp_kv_ready(m_beat[2], m_acc[2], bus.split_value_ready)); else n_pass++;
`ifdef GQA_SCATTER_PERF_EN
            n_checks++; if (kv_stall_cycles !== 32'(e_kv_stall)) $display("FAIL rnd_kvstall c%0d got %0d want %0d", c, kv_stall_cycles, e_kv_stall); else n_pass++;
            n_checks++; if (q_stall_cycles !== 32'(e_q_stall)) $display("FAIL rnd_qstall c%0d got %0d want %0d", c, q_stall_cycles, e_q_stall); else n_pass++;
`endif
            tick();
        end
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    initial begin
        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
        test_reset();
        test_query_sweep();
        test_key_broadcast();
        test_skew();
        test_independent();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fixed_gqa_head_scatter.md
Name: fixed_gqa_head_scatter

Overview:
- Control-path scatter for grouped-query attention (GQA).
- Takes the joint query, key and value streams produced by the batched QKV input block and routes each beat's valid/ready handshake to the owning attention head(s).
- Successor to the plain per-head scatter: NUM_KV_HEADS may be smaller than NUM_HEADS. Each key/value beat is broadcast to every query head in its group and retires only after all group members accept it.
- Data buses are wired to the heads outside this block; head-index outputs are provided for data muxing.

Parameters:
- NUM_HEADS, 12: query heads.
- NUM_KV_HEADS, 4: key/value heads. NUM_HEADS % NUM_KV_HEADS == 0 is required. Setting it equal to NUM_HEADS gives standard MHA.
- HEAD_DIM, 64: embedding elements per head.
- IN_DATA_TENSOR_SIZE_DIM_1, 20: tokens.
- IN_DATA_PARALLELISM_DIM_0, 4: embedding elements per beat. HEAD_DIM % this == 0 is required.
- IN_DATA_PARALLELISM_DIM_1, 4: tokens per beat.
- Derived values:
  - GROUP = NUM_HEADS/NUM_KV_HEADS
  - BPH = HEAD_DIM/IN_DATA_PARALLELISM_DIM_0
  - ROWS = ceil(IN_DATA_TENSOR_SIZE_DIM_1/IN_DATA_PARALLELISM_DIM_1)
  - Q_COLS = NUM_HEADS*BPH
  - KV_COLS = NUM_KV_HEADS*BPH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- query_valid  in  1  joint query beat valid
- query_ready  out  1  joint query beat accepted
- key_valid  in  1  joint key beat valid
- key_ready  out  1  joint key beat retired
- value_valid  in  1  joint value beat valid
- value_ready  out  1  joint value beat retired
- split_query_valid  out  NUM_HEADS  per-head query valid
- split_query_ready  in  NUM_HEADS  per-head query ready
- split_key_valid  out  NUM_HEADS  per-head key valid
- split_key_ready  in  NUM_HEADS  per-head key ready
- split_value_valid  out  NUM_HEADS  per-head value valid
- split_value_ready  in  NUM_HEADS  per-head value ready
- query_head_idx  out  clog2(NUM_HEADS)  head owning current query beat
- kv_group_idx  out  clog2(NUM_KV_HEADS)  group owning current key beat (value uses same formula, separate counter internally)

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Beat order per stream:
  - Column blocks 0..COLS-1 of row block 0, then row block 1, and so on through row block ROWS-1.
  - After the last beat of the last row block, the stream wraps to (col 0, row 0) for the next tensor.
- Counters: each of the three streams (query, key, value) has its own col_cnt and row_cnt. The streams advance independently; no cross-stream lockstep.
- Query routing:
  - h = q_col/BPH.
  - split_query_valid = query_valid << h (one-hot).
  - query_ready = split_query_ready[h].
  - Counter advances on query_valid & query_ready.
  - Combinational, zero latency.
- Key routing (value is identical, with its own state):
  - g = k_col/BPH; group heads are g*GROUP .. g*GROUP+GROUP-1.
  - A GROUP-bit done mask is registered.
  - split_key_valid[g*GROUP+i] = key_valid & ~done[i]; all other heads see 0.
  - On a cycle where split_key_valid[...]&split_key_ready[...] is high for member i, done[i] is set next cycle.
  - key_ready = AND over i of (done[i] | split_key_ready[g*GROUP+i]); it is combinational and is asserted in the cycle the last pending member accepts.
  - On key_valid & key_ready: the done mask clears to 0 and the counter advances.
  - A member that has already accepted is never presented the same beat again.
  - GROUP==1 degenerates to one-hot routing with no extra latency.
- Simultaneous events:
  - All group members ready in the same cycle → the beat retires in one cycle; the mask stays 0.
  - key_valid dropping mid-broadcast is illegal (AXI-style stability required). A bench assertion flags it.
- Reset: rst clears all counters and done masks. Reset outputs:
  - All split_*_valid = 0.
  - query_head_idx = 0.
  - kv_group_idx = 0.
  - *_ready follows the combinational rule with state cleared.
- Reset mid-broadcast: partially delivered beats are discarded; the next beat is col 0, row 0.
- Counter widths: clog2 of Q_COLS, KV_COLS and ROWS respectively, minimum 1 bit.

Optional Feature:
- Macro: GQA_SCATTER_PERF_EN.
- Defined: adds output ports kv_stall_cycles (32-bit) and q_stall_cycles (32-bit).
  - kv_stall_cycles increments each cycle that key_valid or value_valid is high with a partially set done mask (broadcast skew).
  - q_stall_cycles increments each cycle that query_valid & ~query_ready.
  - Both saturate at 2^32-1 and clear on rst.
- Undefined: ports and logic are absent; routing behaviour is identical.

Test Plan:
All scenarios use NUM_HEADS=4, NUM_KV_HEADS=2, HEAD_DIM=8, PAR_0=4, DIM_1=4, PAR_1=2, giving GROUP=2, BPH=2, Q_COLS=8, KV_COLS=4, ROWS=2.
1. Query sweep, all split ready=1: 16 beats → head sequence 0,0,1,1,2,2,3,3 repeated twice; query_ready high every cycle; wraps to head 0 on beat 17.
2. Key broadcast, split_key_ready=4'b1111: beat 0 → split_key_valid=4'b0011, retires in 1 cycle; beat 2 → 4'b1100.
3. Skewed broadcast: beat 0 with head0 ready at cycle 0 and head1 ready at cycle 3 → head0 valid drops after cycle 0, key_ready=1 only at cycle 3, each head accepts exactly once.
4. Independent streams: value stalled (ready=0) while key streams 4 beats → key group index reaches 1 while the value counter remains at 0.
5. rst asserted at cycle 2 of a skewed broadcast → done mask cleared, next key beat goes to group 0 col 0, split_key_valid=4'b0011.
6. With GQA_SCATTER_PERF_EN defined: repeat scenario 3 → kv_stall_cycles=3; rst → 0.
